// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - fetch front end: single-outstanding imem requests into a DEPTH-entry pc4/instr FIFO
// Optional discard/full performance counters are compiled in with IFQ_PERF_CNT_EN.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        ifq_ready_i,
    output logic        ifq_valid_o,
    output logic [31:0] ifq_pc4_o,
    output logic [31:0] ifq_instr_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [15:0] perf_drop_cnt_o,
    output logic [15:0] perf_full_cnt_o
`endif
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc4_mem   [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic          issue, enq, deq;

    // The response slot is reserved at issue time, so a response can always be enqueued.
    assign issue = (state_q == S_IDLE) & !redirect_i & !rst_i & (count_q < FULL);
    assign enq   = (state_q == S_WAIT) & imem_rvalid_i & !redirect_i;
    assign deq   = ifq_valid_o & ifq_ready_i & !redirect_i;

    assign imem_req_o  = issue;
    assign imem_addr_o = fetch_pc_q;
    assign ifq_valid_o = (count_q != '0);
    assign ifq_pc4_o   = ifq_valid_o ? pc4_mem[head_q]   : 32'h0;
    assign ifq_instr_o = ifq_valid_o ? instr_mem[head_q] : 32'h0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (issue) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid_i)   state_d = S_IDLE;
                else if (redirect_i) state_d = S_DROP;
            end
            S_DROP: if (imem_rvalid_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ALIGN_MASK;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                req_pc_d   = fetch_pc_q;
            end
            tail_d  = tail_q + PW'(enq);
            head_d  = head_q + PW'(deq);
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC & ALIGN_MASK;
            req_pc_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            pc4_mem[tail_q]   <= req_pc_q + 32'd4;
            instr_mem[tail_q] <= imem_rdata_i;
        end
    end

`ifdef IFQ_PERF_CNT_EN
    logic [15:0] drop_cnt_q, full_cnt_q;
    logic        drop_ev, full_ev;

    assign drop_ev = imem_rvalid_i & ((state_q == S_DROP) | ((state_q == S_WAIT) & redirect_i));
    assign full_ev = (state_q == S_IDLE) & (count_q == FULL) & !redirect_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
            full_cnt_q <= '0;
        end else begin
            if (drop_ev && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
            if (full_ev && (full_cnt_q != 16'hFFFF)) full_cnt_q <= full_cnt_q + 16'd1;
        end
    end

    assign perf_drop_cnt_o = drop_cnt_q;
    assign perf_full_cnt_o = full_cnt_q;
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        req;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;
`ifdef IFQ_PERF_CNT_EN
    logic [15:0] perf_drop;
    logic [15:0] perf_full;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Memory responder state: one pending response, delivered lat cycles after the request.
    int          lat = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;
    logic [31:0] req_log [16];
    int          n_req = 0;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .ifq_ready_i   (ready),
        .ifq_valid_o   (valid),
        .ifq_pc4_o     (pc4),
        .ifq_instr_o   (instr),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_rvalid_i (rvalid),
        .imem_rdata_i  (rdata)
`ifdef IFQ_PERF_CNT_EN
        ,
        .perf_drop_cnt_o (perf_drop),
        .perf_full_cnt_o (perf_full)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2001_0005 : (32'hC0DE_0000 ^ a);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (req === 1'b1) begin
            if (n_req < 16) req_log[n_req] = addr;
            n_req++;
            pend  = 1'b1;
            cnt   = lat;
            paddr = addr;
        end
        @(posedge clk);
        #1;
        rvalid = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                rvalid = 1'b1;
                rdata  = instr_of(paddr);
                pend   = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        redirect = 1'b0;
        rvalid   = 1'b0;
        pend     = 1'b0;
        tick();
        tick();
        rst   = 1'b0;
        n_req = 0;
        #1;
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b0;
        rvalid = 1'b0; rdata = 32'h0;

        // Reset state
        tick();
        tick();
        check("rst_valid", valid, 32'h0);
        check("rst_req", req, 32'h0);
        check("rst_pc4", pc4, 32'h0);
        check("rst_instr", instr, 32'h0);
`ifdef IFQ_PERF_CNT_EN
        check("rst_perf_drop", perf_drop, 32'h0);
        check("rst_perf_full", perf_full, 32'h0);
`endif

        // First fetch after reset release, 1-cycle memory
        lat = 1; ready = 1'b1;
        rst = 1'b0; n_req = 0; #1;
        check("t1_req", req, 32'h1);
        check("t1_addr", addr, 32'h0);
        tick();
        check("t1_wait_req", req, 32'h0);
        check("t1_wait_valid", valid, 32'h0);
        tick();
        check("t1_valid", valid, 32'h1);
        check("t1_pc4", pc4, 32'h4);
        check("t1_instr", instr, 32'h2001_0005);
        check("t1_req2", req, 32'h1);
        check("t1_addr2", addr, 32'h4);

        // Fill with ready low: exactly four requests, then stall until a dequeue
        ready = 1'b0;
        do_reset();
        for (int i = 0; i < 12; i++) tick();
        check("t2_nreq", n_req, 32'd4);
        check("t2_addr0", req_log[0], 32'h0);
        check("t2_addr1", req_log[1], 32'h4);
        check("t2_addr2", req_log[2], 32'h8);
        check("t2_addr3", req_log[3], 32'hC);
        check("t2_full_req", req, 32'h0);
        check("t2_head_pc4", pc4, 32'h4);
`ifdef IFQ_PERF_CNT_EN
        check("t2_perf_full", perf_full, 32'd4);
`endif
        ready = 1'b1;
        tick();
        ready = 1'b0; #1;
        check("t2_resume_req", req, 32'h1);
        check("t2_resume_addr", addr, 32'h10);
        check("t2_new_head_pc4", pc4, 32'h8);
        check("t2_new_head_instr", instr, 32'hC0DE_0004);

        // Redirect with two entries queued while idle
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0043; ready = 1'b1; #1;
        check("t3_redir_req", req, 32'h0);
        check("t3_redir_valid", valid, 32'h1);
        tick();
        redirect = 1'b0; ready = 1'b0; #1;
        check("t3_flushed_valid", valid, 32'h0);
        check("t3_req", req, 32'h1);
        check("t3_addr", addr, 32'h40);

        // 3-cycle memory, redirect one cycle after the request to 0x8
        lat = 3;
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        check("t4_req8", req, 32'h1);
        check("t4_addr8", addr, 32'h8);
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0; #1;
        check("t4_drop_req", req, 32'h0);
        tick();
        check("t4_rvalid_req", req, 32'h0);
        tick();
        check("t4_valid", valid, 32'h0);
        check("t4_req", req, 32'h1);
        check("t4_addr", addr, 32'h100);
`ifdef IFQ_PERF_CNT_EN
        check("t4_perf_drop", perf_drop, 32'd1);
`endif

        // Redirect coinciding with the response in S_WAIT
        lat = 1;
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0; #1;
        check("t5_valid", valid, 32'h0);
        check("t5_req", req, 32'h1);
        check("t5_addr", addr, 32'h200);
`ifdef IFQ_PERF_CNT_EN
        check("t5_perf_drop", perf_drop, 32'd2);
`endif
        tick();
        tick();
        check("t5_entry_valid", valid, 32'h1);
        check("t5_entry_pc4", pc4, 32'h204);
        check("t5_entry_instr", instr, 32'hC0DE_0200);

        // Reset during S_WAIT, then a stray response while idle
        lat = 3;
        tick();
        rst = 1'b1; pend = 1'b0;
        tick();
        check("t6_rst_valid", valid, 32'h0);
        rst = 1'b0; lat = 1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; #1;
        check("t6_req", req, 32'h1);
        check("t6_addr", addr, 32'h0);
        tick();
        check("t6_stray_valid", valid, 32'h0);
        tick();
        check("t6_valid", valid, 32'h1);
        check("t6_pc4", pc4, 32'h4);
        check("t6_instr", instr, 32'h2001_0005);

        // Redirect to the top word: pc4 and next fetch wrap to zero
        do_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0; #1;
        check("t7_addr_top", addr, 32'hFFFF_FFFC);
        tick();
        tick();
        check("t7_valid", valid, 32'h1);
        check("t7_pc4_wrap", pc4, 32'h0);
        check("t7_instr", instr, 32'h3F21_FFFC);
        check("t7_addr_wrap", addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
